// File: rtl/mux_sel_arbiter.sv
// Round-robin 4-source arbiter driving the mux select; one-cycle Req-to-grant latency, grant held
// until Ack, request drop or MAX_HOLD timeout (0 = no timeout). Define MUX_SEL_ARB_LOCK_EN for Lock.
module mux_sel_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [3:0] Req,
  input  logic       Ack,
`ifdef MUX_SEL_ARB_LOCK_EN
  input  logic       Lock,
`endif
  output logic [1:0] Sel,
  output logic [3:0] Grant,
  output logic       Valid,
  output logic       Timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(MAX_HOLD - 1);
  localparam bit         TO_EN     = (MAX_HOLD != 0);

  state_t     state_q, state_nxt;
  logic [1:0] sel_q, sel_nxt;
  logic [1:0] ptr_q, ptr_nxt;
  logic [7:0] cnt_q, cnt_nxt;
  logic [3:0] grant_q, grant_nxt;
  logic       valid_q, valid_nxt;
  logic       timeout_q, timeout_nxt;

  logic       lock;
  logic [3:0] cand;
  logic       win_vld;
  logic [1:0] win_idx;
  logic [1:0] idx;
  logic       req_held, drop, to_hit, end_grant;

`ifdef MUX_SEL_ARB_LOCK_EN
  assign lock = Lock;
`else
  assign lock = 1'b0;
`endif

  // The released source is masked for the handover decision only.
  always_comb begin
    cand    = (state_q == GRANT) ? (Req & ~(4'b0001 << sel_q)) : Req;
    win_vld = 1'b0;
    win_idx = ptr_q;
    idx     = ptr_q;
    // Walk from the farthest slot back so the nearest set bit after the pointer wins.
    for (int i = 4; i >= 1; i--) begin
      idx = ptr_q + 2'(i);
      if (cand[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end

  assign req_held  = Req[sel_q];
  assign drop      = !req_held && !lock;
  assign to_hit    = TO_EN && (cnt_q == 8'd0) && !lock;
  assign end_grant = Ack || drop || to_hit;

  always_comb begin
    state_nxt   = state_q;
    sel_nxt     = sel_q;
    ptr_nxt     = ptr_q;
    cnt_nxt     = cnt_q;
    grant_nxt   = grant_q;
    valid_nxt   = valid_q;
    timeout_nxt = 1'b0;
    case (state_q)
      IDLE: begin
        valid_nxt = 1'b0;
        grant_nxt = 4'b0000;
        if (win_vld) begin
          state_nxt = GRANT;
          sel_nxt   = win_idx;
          ptr_nxt   = win_idx;
          cnt_nxt   = HOLD_LOAD;
          valid_nxt = 1'b1;
          grant_nxt = 4'b0001 << win_idx;
        end
      end
      GRANT: begin
        if (end_grant) begin
          // Ack wins over a coincident timeout; a dropped request is a normal release.
          timeout_nxt = to_hit && !Ack && req_held;
          if (win_vld) begin
            sel_nxt   = win_idx;
            ptr_nxt   = win_idx;
            cnt_nxt   = HOLD_LOAD;
            valid_nxt = 1'b1;
            grant_nxt = 4'b0001 << win_idx;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
            valid_nxt = 1'b0;
            grant_nxt = 4'b0000;
          end
        end else if (!lock && cnt_q != 8'd0) begin
          cnt_nxt = cnt_q - 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      sel_q     <= 2'b00;
      ptr_q     <= 2'd3;
      cnt_q     <= 8'd0;
      grant_q   <= 4'b0000;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      sel_q     <= sel_nxt;
      ptr_q     <= ptr_nxt;
      cnt_q     <= cnt_nxt;
      grant_q   <= grant_nxt;
      valid_q   <= valid_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  assign Sel     = sel_q;
  assign Grant   = grant_q;
  assign Valid   = valid_q;
  assign Timeout = timeout_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: two instances (MAX_HOLD 4 and 2) against a behavioural model.
module tb_mux_sel_arbiter;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic [3:0] Req = 4'b0000;
  logic       Ack = 1'b0;

  logic [1:0] sel_a, sel_b;
  logic [3:0] gnt_a, gnt_b;
  logic       vld_a, vld_b, to_a, to_b;

  int n_checks = 0;
  int n_fail   = 0;

  int mh[2]     = '{4, 2};
  int m_gnt[2];
  int m_ptr[2];
  int m_held[2];
  int m_sel[2];
  bit m_to[2];
  int rot[5]    = '{0, 1, 2, 3, 0};

  mux_sel_arbiter #(.MAX_HOLD(4)) u_dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Ack(Ack),
    .Sel(sel_a), .Grant(gnt_a), .Valid(vld_a), .Timeout(to_a)
  );

  mux_sel_arbiter #(.MAX_HOLD(2)) u_dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Ack(Ack),
    .Sel(sel_b), .Grant(gnt_b), .Valid(vld_b), .Timeout(to_b)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // First requester after the pointer in rotation order, skipping 'excl'; -1 if none.
  function automatic int pick(input logic [3:0] r, input int p, input int excl);
    for (int i = 1; i <= 4; i++) begin
      int j;
      j = (p + i) % 4;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_gnt[k]  = -1;
      m_ptr[k]  = 3;
      m_held[k] = 0;
      m_sel[k]  = 0;
      m_to[k]   = 1'b0;
    end
  endtask

  task automatic grant_to(input int k, input int w);
    m_gnt[k]  = w;
    m_ptr[k]  = w;
    m_sel[k]  = w;
    m_held[k] = 0;
  endtask

  task automatic model_step(input int k);
    int  w;
    bit  drop, tmo;
    m_to[k] = 1'b0;
    if (m_gnt[k] < 0) begin
      w = pick(Req, m_ptr[k], -1);
      if (w >= 0) grant_to(k, w);
    end else begin
      drop = !Req[m_gnt[k]];
      tmo  = (mh[k] != 0) && (m_held[k] + 1 >= mh[k]);
      if (Ack || drop || tmo) begin
        m_to[k] = tmo && !Ack && !drop;
        w = pick(Req, m_ptr[k], m_gnt[k]);
        if (w >= 0) grant_to(k, w);
        else m_gnt[k] = -1;
      end else begin
        m_held[k]++;
      end
    end
  endtask

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) model_reset();
    else for (int k = 0; k < 2; k++) model_step(k);
  end

  function automatic logic [3:0] exp_gnt(input int k);
    return (m_gnt[k] >= 0) ? (4'b0001 << m_gnt[k]) : 4'b0000;
  endfunction

  task automatic compare_all();
    chk("sel_a", sel_a, m_sel[0]);
    chk("gnt_a", gnt_a, exp_gnt(0));
    chk("vld_a", vld_a, m_gnt[0] >= 0);
    chk("to_a",  to_a,  m_to[0]);
    chk("sel_b", sel_b, m_sel[1]);
    chk("gnt_b", gnt_b, exp_gnt(1));
    chk("vld_b", vld_b, m_gnt[1] >= 0);
    chk("to_b",  to_b,  m_to[1]);
  endtask

  task automatic step_cyc();
    @(posedge Clk);
    @(negedge Clk);
    compare_all();
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    Req   = 4'b0000;
    Ack   = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // Reset and idle
    for (int c = 0; c < 10; c++) begin
      step_cyc();
      chk("idle_sel", sel_a, 2'b00);
      chk("idle_gnt", gnt_a, 4'b0000);
      chk("idle_vld", vld_a, 1'b0);
      chk("idle_to",  to_a,  1'b0);
    end

    // Single request, Ack three cycles later with Req cleared
    Req = 4'b0100;
    step_cyc();
    chk("single_sel", sel_a, 2'b10);
    chk("single_gnt", gnt_a, 4'b0100);
    chk("single_vld", vld_a, 1'b1);
    step_cyc();
    step_cyc();
    Ack = 1'b1;
    Req = 4'b0000;
    step_cyc();
    chk("single_drop_vld", vld_a, 1'b0);
    chk("single_drop_gnt", gnt_a, 4'b0000);
    Ack = 1'b0;
    step_cyc();

    // Round-robin rotation with Ack every cycle
    do_reset();
    Req = 4'b1111;
    Ack = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step_cyc();
      chk("rot_sel_a", sel_a, rot[c]);
      chk("rot_vld_a", vld_a, 1'b1);
      chk("rot_sel_b", sel_b, rot[c]);
    end
    Ack = 1'b0;
    Req = 4'b0000;
    step_cyc();

    // Timeout on the MAX_HOLD=4 instance
    do_reset();
    Req = 4'b0011;
    for (int c = 0; c < 4; c++) begin
      step_cyc();
      chk("tmo_hold_sel", sel_a, 2'b00);
      chk("tmo_hold_vld", vld_a, 1'b1);
      chk("tmo_hold_to",  to_a,  1'b0);
    end
    step_cyc();
    chk("tmo_pulse", to_a, 1'b1);
    chk("tmo_sel",   sel_a, 2'b01);
    chk("tmo_vld",   vld_a, 1'b1);
    step_cyc();
    chk("tmo_once", to_a, 1'b0);
    Req = 4'b0000;
    step_cyc();

    // Ack coincident with timeout on the MAX_HOLD=2 instance
    do_reset();
    Req = 4'b0011;
    step_cyc();
    step_cyc();
    Ack = 1'b1;
    step_cyc();
    chk("ack_tmo_to",  to_b,  1'b0);
    chk("ack_tmo_sel", sel_b, 2'b01);
    chk("ack_tmo_vld", vld_b, 1'b1);
    Ack = 1'b0;
    Req = 4'b0000;
    step_cyc();

    // Asynchronous reset while Sel = 11
    do_reset();
    Req = 4'b1000;
    step_cyc();
    chk("arst_pre_sel", sel_a, 2'b11);
    #2 Rst_n = 1'b0;
    #1;
    chk("arst_vld", vld_a, 1'b0);
    chk("arst_gnt", gnt_a, 4'b0000);
    chk("arst_sel", sel_a, 2'b00);
    @(negedge Clk);
    Rst_n = 1'b1;
    step_cyc();
    chk("arst_regrant", gnt_a, 4'b1000);
    chk("arst_regrant_vld", vld_a, 1'b1);

    // Randomised traffic against the model, with occasional async resets
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 1) == 1) Req = 4'($urandom_range(0, 15));
      Ack = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 Rst_n = 1'b0;
        #1 compare_all();
        @(negedge Clk);
        Rst_n = 1'b1;
      end
      step_cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_sel_arbiter.md
# mux_sel_arbiter

Round-robin arbiter that generates the 2-bit select for the 4-to-1 multiplexer stage. Four sources raise requests. The arbiter grants one source at a time and drives `Sel` so the downstream mux routes that source to `Y`. It holds each grant until the consumer acknowledges it, the requester withdraws, or a configurable timeout expires. `Grant` and `Valid` qualify the mux output for the consumer.

## Interface
- `MAX_HOLD`, default 16: maximum cycles a grant may be held without `Ack`.
  - Legal range is 0..255.
  - 0 disables the timeout.
- `Clk` input 1: single clock; everything is sampled on the rising edge.
- `Rst_n` input 1: reset, asynchronous and active-low.
- `Req` input [3:0]: request from sources A/B/C/D (bit 0 = A, mapping to `Sel` 2'b00).
- `Ack` input 1: consumer has taken the current mux output; valid only while `Valid` = 1.
- `Sel` output [1:0]: mux select, registered.
- `Grant` output [3:0]: one-hot grant, registered; equals `1 << Sel` while `Valid` = 1, otherwise 0.
- `Valid` output 1: a grant is active and `Y` of the mux is meaningful.
- `Timeout` output 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- Reset values: `Sel` = 2'b00, `Grant` = 4'b0000, `Valid` = 0, `Timeout` = 0, internal last-grant pointer = 3 (so source 0 has first priority), hold counter = 0, state = IDLE.
- States:
  - IDLE: `Valid` = 0; `Sel` keeps its last value. If any `Req` bit is set, pick a winner and go to GRANT.
  - GRANT: `Valid` = 1 and `Grant` is one-hot. The grant ends on the first of these:
    - `Ack` = 1;
    - the granted `Req` bit = 0;
    - timeout, when `MAX_HOLD` != 0 and the counter is 0.
- Winner selection: the first set `Req` bit searching from pointer+1 upward, modulo 4. On a grant, the pointer is loaded with the winner's index.
- Counter:
  - On entering GRANT (from IDLE or by handover), load `MAX_HOLD`-1.
  - Decrement each cycle while in GRANT; saturate at 0.
  - Width is 8 bits.
- Handover: at the grant-ending edge the next winner is selected from `Req` sampled on that same edge, excluding the source just released.
  - If a winner exists, stay in GRANT with the new `Sel` and keep `Valid` at 1; there is no bubble.
  - If no winner exists, go to IDLE.
- Released source: it is excluded only for that one handover decision. If it is the only requester, the next grant to it occurs one cycle later via IDLE.
- Simultaneous events:
  - `Ack` together with timeout counts as `Ack`; `Timeout` stays 0.
  - `Ack` together with the `Req` drop is a normal end.
  - A `Req` change on a non-granted source never disturbs the current grant.
- `Ack` while `Valid` = 0 is ignored.
- `Rst_n` low mid-grant forces all reset values immediately, without waiting for the clock.

## Timing
- Latency: `Req` asserted before edge N gives `Sel`/`Grant`/`Valid` updated after edge N, i.e. one cycle.
- `Ack` sampled high at edge N: the new grant, or `Valid` = 0, is visible after edge N.
- Timeout with `MAX_HOLD` = M: a grant issued at edge N is revoked at edge N+M if `Ack` never arrives. `Timeout` is high for the cycle following edge N+M.
- `MAX_HOLD` = 1: the grant lasts exactly one cycle unless `Ack` is high in that cycle.
- Outputs are glitch-free registers; `Sel` changes only on `Clk` edges or reset.

## Configuration
- `MUX_SEL_ARB_LOCK_EN` defined:
  - Adds input port `Lock` (1 bit).
  - While `Lock` = 1 in GRANT, timeout revocation and `Req`-drop release are suppressed and the counter is frozen.
  - `Ack` still ends the grant.
- Not defined: no `Lock` port; behaviour is exactly as described above.

## Test plan
- Reset and idle:
  - Stimulus: hold `Rst_n` = 0, then release it with `Req` = 4'b0000.
  - Required: `Sel` = 00, `Grant` = 0000, `Valid` = 0, `Timeout` = 0 for 10 cycles.
- Single request:
  - Stimulus: `Req` = 4'b0100, then `Ack` pulse 3 cycles later.
  - Required: `Sel` = 10 and `Grant` = 0100 one cycle after `Req`. `Valid` drops the cycle after `Ack` when `Req` is cleared.
- Round-robin rotation:
  - Stimulus: `Req` = 4'b1111 held, with `Ack` = 1 every cycle.
  - Required: `Sel` sequence 00, 01, 10, 11, 00, and `Valid` stays 1 throughout.
- Timeout:
  - Stimulus: `MAX_HOLD` = 4, `Req` = 4'b0011, no `Ack`.
  - Required: source 0 is granted for 4 cycles, `Timeout` pulses once, then `Sel` = 01 with no `Valid` gap.
- Simultaneous `Ack` and timeout:
  - Stimulus: `MAX_HOLD` = 2, `Ack` in the 2nd granted cycle.
  - Required: `Timeout` = 0 and a normal handover.
- Asynchronous reset mid-grant:
  - Stimulus: `Rst_n` low between clock edges while `Sel` = 11.
  - Required: `Valid`/`Grant`/`Sel` go to 0/0000/00 immediately. After release, `Req` = 4'b1000 gives `Grant` = 1000 within one cycle.
